// File: rtl/g11620_scan_ctrl_pkg.sv
// Shared definitions for the G11620 scan sequencer: config RAM map, CTRL bits,
// error codes, FSM encoding and the captured-configuration record.
package g11620_scan_ctrl_pkg;

  // Config RAM word addresses. Word 1 holds the integration time, which the
  // sensor controller reads on its own, so the sequencer never fetches it.
  localparam logic [7:0] ADDR_CTRL = 8'd0;
  localparam logic [7:0] ADDR_STP  = 8'd2;
  localparam logic [7:0] ADDR_PW   = 8'd3;
  localparam logic [7:0] ADDR_SCAN = 8'd4;
  localparam logic [7:0] ADDR_SP   = 8'd5;
  localparam logic [7:0] ADDR_EP   = 8'd6;

  // CTRL register bits
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_CONT_BIT = 1;

  // Number of config words fetched per LOAD
  localparam int unsigned LOAD_READS = 6;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_DISABLED = 3'd1,
    ERR_ZERO_CNT = 3'd2,
    ERR_BAD_WIN  = 3'd3,
    ERR_TIMEOUT  = 3'd4,
    ERR_ABORT    = 3'd5
  } err_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_START,
    S_WAIT,
    S_PERIOD,
    S_FINISH,
    S_ERR
  } state_e;

  // Configuration words as captured during LOAD
  typedef struct packed {
    logic [31:0] ctrl;
    logic [31:0] stp;
    logic [31:0] pw;
    logic [31:0] scan;
    logic [31:0] sp;
    logic [31:0] ep;
  } cfg_t;

  // Address of the n-th read in the LOAD sequence
  function automatic logic [7:0] load_addr(input logic [2:0] slot);
    case (slot)
      3'd0:    load_addr = ADDR_CTRL;
      3'd1:    load_addr = ADDR_STP;
      3'd2:    load_addr = ADDR_PW;
      3'd3:    load_addr = ADDR_SCAN;
      3'd4:    load_addr = ADDR_SP;
      default: load_addr = ADDR_EP;
    endcase
  endfunction

endpackage

// File: rtl/g11620_scan_ctrl_cfg_loader.sv
// Config loader: issues the six config RAM reads on consecutive cycles and
// captures each response the cycle after its read. The whole sequence takes
// seven cycles; done is high during the last one, so the captured words are
// stable from the following cycle on.
module g11620_cfg_loader
  import g11620_scan_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        rd,
  output logic [7:0]  addr,
  input  logic [31:0] din,
  output logic        done,
  output cfg_t        cfg
);

  logic       active;
  logic [2:0] phase;       // cycle index within the load, 0..6
  logic [2:0] next_phase;

  assign next_phase = phase + 3'd1;

  // Read sequencing and one-cycle-late capture of each returned word
  always_ff @(posedge clk) begin
    // NOTE: every register here is state, so non-blocking assignment keeps
    // all updates in this block referring to the pre-edge values.
    if (rst) begin
      active <= 1'b0;
      phase  <= 3'd0;
      rd     <= 1'b0;
      addr   <= 8'd0;
      done   <= 1'b0;
      cfg    <= '0;
    end else if (abort) begin
      active <= 1'b0;
      phase  <= 3'd0;
      rd     <= 1'b0;
      addr   <= 8'd0;
      done   <= 1'b0;
    end else if (start) begin
      // First read is presented in the first LOAD cycle
      active <= 1'b1;
      phase  <= 3'd0;
      rd     <= 1'b1;
      addr   <= load_addr(3'd0);
      done   <= 1'b0;
    end else if (active) begin
      phase <= next_phase;
      rd    <= (next_phase < 3'(LOAD_READS));
      addr  <= (next_phase < 3'(LOAD_READS)) ? load_addr(next_phase) : 8'd0;
      done  <= (next_phase == 3'(LOAD_READS));
      // Data for the read issued in phase p-1 is on din during phase p
      case (phase)
        3'd1:    cfg.ctrl <= din;
        3'd2:    cfg.stp  <= din;
        3'd3:    cfg.pw   <= din;
        3'd4:    cfg.scan <= din;
        3'd5:    cfg.sp   <= din;
        3'd6:    cfg.ep   <= din;
        default: ;
      endcase
      if (phase == 3'(LOAD_READS)) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/g11620_scan_ctrl.sv
// G11620 scan sequencer top: loads and validates the scan configuration,
// issues sensor start pulses, supervises each scan with a timeout, spaces
// scans by the programmed period and reports progress and errors.
module g11620_scan_ctrl
  import g11620_scan_ctrl_pkg::*;
#(
  parameter int unsigned PIX_NUM     = 511,
  parameter logic [31:0] TMO_DEFAULT = 32'd100000
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        host_start,
  input  logic        host_abort,
  output logic        cfg_ram_rd_o,
  output logic [7:0]  cfg_ram_addr_o,
  input  logic [31:0] cfg_ram_din,
  output logic        sens_start_o,
  output logic        sens_soft_reset_o,
  input  logic        sens_done_in,
  output logic [8:0]  sp_o,
  output logic [8:0]  ep_o,
  output logic [15:0] scan_idx_o,
  output logic        busy_o,
  output logic        seq_done_o,
  output logic        err_o,
  output logic [2:0]  err_code_o
);

  state_e      state;
  cfg_t        cfg;
  logic        ld_start;
  logic        ld_abort;
  logic        ld_done;
  logic [31:0] tmo_cnt;
  logic [31:0] per_cnt;
  logic [31:0] tmo_load;
  logic [15:0] scan_next;
  logic        cfg_en;
  logic        cfg_cont;
  logic        win_bad;
  logic        unused_cfg_bits;

  assign busy_o    = (state != S_IDLE);
  assign ld_start  = (state == S_IDLE) && host_start;
  assign ld_abort  = (state != S_IDLE) && host_abort;
  assign cfg_en    = cfg.ctrl[CTRL_EN_BIT];
  assign cfg_cont  = cfg.ctrl[CTRL_CONT_BIT];
  assign scan_next = scan_idx_o + 16'd1;
  assign tmo_load  = (cfg.pw == 32'd0) ? TMO_DEFAULT : cfg.pw;
  assign win_bad   = (cfg.sp > cfg.ep) || (cfg.ep > 32'(PIX_NUM));

  // Only the low bits of CTRL and SCAN carry meaning
  assign unused_cfg_bits = ^{cfg.ctrl[31:2], cfg.scan[31:16]};

  g11620_cfg_loader u_loader (
    .clk   (clk),
    .rst   (rst),
    .start (ld_start),
    .abort (ld_abort),
    .rd    (cfg_ram_rd_o),
    .addr  (cfg_ram_addr_o),
    .din   (cfg_ram_din),
    .done  (ld_done),
    .cfg   (cfg)
  );

  // Sequencer FSM with registered pulse, status and counter outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      sens_start_o      <= 1'b0;
      sens_soft_reset_o <= 1'b0;
      seq_done_o        <= 1'b0;
      err_o             <= 1'b0;
      err_code_o        <= ERR_NONE;
      scan_idx_o        <= 16'd0;
      sp_o              <= 9'd0;
      ep_o              <= 9'd0;
      tmo_cnt           <= 32'd0;
      per_cnt           <= 32'd0;
    end else begin
      // NOTE: single-cycle pulses default low here and are raised only on
      // the transition into the state they belong to.
      sens_start_o      <= 1'b0;
      sens_soft_reset_o <= 1'b0;
      seq_done_o        <= 1'b0;

      if (ld_abort) begin
        // Abort outranks every other event in the cycle
        state             <= S_IDLE;
        sens_soft_reset_o <= 1'b1;
        err_o             <= 1'b1;
        err_code_o        <= ERR_ABORT;
      end else begin
        case (state)
          S_IDLE: begin
            if (host_start) begin
              state      <= S_LOAD;
              err_o      <= 1'b0;
              err_code_o <= ERR_NONE;
              scan_idx_o <= 16'd0;
            end
          end

          S_LOAD: begin
            if (ld_done) begin
              state <= S_CHECK;
            end
          end

          S_CHECK: begin
            if (!cfg_en) begin
              state      <= S_ERR;
              err_o      <= 1'b1;
              err_code_o <= ERR_DISABLED;
            end else if ((cfg.scan[15:0] == 16'd0) && !cfg_cont) begin
              state      <= S_ERR;
              err_o      <= 1'b1;
              err_code_o <= ERR_ZERO_CNT;
            end else if (win_bad) begin
              state      <= S_ERR;
              err_o      <= 1'b1;
              err_code_o <= ERR_BAD_WIN;
            end else begin
              sp_o         <= cfg.sp[8:0];
              ep_o         <= cfg.ep[8:0];
              state        <= S_START;
              sens_start_o <= 1'b1;
            end
          end

          S_START: begin
            tmo_cnt <= tmo_load;
            state   <= S_WAIT;
          end

          S_WAIT: begin
            tmo_cnt <= tmo_cnt - 32'd1;
            // A done arriving on the last timeout cycle still counts
            if (sens_done_in) begin
              scan_idx_o <= scan_next;
              if (!cfg_cont && (scan_next == cfg.scan[15:0])) begin
                state      <= S_FINISH;
                seq_done_o <= 1'b1;
              end else begin
                state   <= S_PERIOD;
                per_cnt <= cfg.stp;
              end
            end else if (tmo_cnt <= 32'd1) begin
              state             <= S_ERR;
              sens_soft_reset_o <= 1'b1;
              err_o             <= 1'b1;
              err_code_o        <= ERR_TIMEOUT;
            end
          end

          S_PERIOD: begin
            // Spends max(STP,1) cycles here, so start pulses never abut
            if (per_cnt <= 32'd1) begin
              state        <= S_START;
              sens_start_o <= 1'b1;
            end else begin
              per_cnt <= per_cnt - 32'd1;
            end
          end

          S_FINISH: state <= S_IDLE;
          S_ERR:    state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_g11620_scan_ctrl.sv
// Directed bench for g11620_scan_ctrl: config RAM model, simple sensor model
// answering each start after a programmable delay, and event monitors.
module tb_g11620_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        host_start;
  logic        host_abort;
  logic        cfg_ram_rd_o;
  logic [7:0]  cfg_ram_addr_o;
  logic [31:0] cfg_ram_din;
  logic        sens_start_o;
  logic        sens_soft_reset_o;
  logic        sens_done_in;
  logic [8:0]  sp_o;
  logic [8:0]  ep_o;
  logic [15:0] scan_idx_o;
  logic        busy_o;
  logic        seq_done_o;
  logic        err_o;
  logic [2:0]  err_code_o;

  g11620_scan_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .host_start        (host_start),
    .host_abort        (host_abort),
    .cfg_ram_rd_o      (cfg_ram_rd_o),
    .cfg_ram_addr_o    (cfg_ram_addr_o),
    .cfg_ram_din       (cfg_ram_din),
    .sens_start_o      (sens_start_o),
    .sens_soft_reset_o (sens_soft_reset_o),
    .sens_done_in      (sens_done_in),
    .sp_o              (sp_o),
    .ep_o              (ep_o),
    .scan_idx_o        (scan_idx_o),
    .busy_o            (busy_o),
    .seq_done_o        (seq_done_o),
    .err_o             (err_o),
    .err_code_o        (err_code_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Config RAM: data returned exactly one cycle after the read strobe
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (cfg_ram_rd_o) cfg_ram_din <= mem[cfg_ram_addr_o];
  end

  // Cycle counter
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Event monitors, sampled mid-cycle
  int         n_start = 0;
  int         n_srst  = 0;
  int         n_seqd  = 0;
  int         n_rd    = 0;
  int         start_cyc [0:63];
  logic [7:0] addr_log  [0:255];
  initial forever begin
    @(negedge clk);
    if (sens_start_o) begin
      start_cyc[n_start % 64] = cyc;
      n_start++;
    end
    if (sens_soft_reset_o) n_srst++;
    if (seq_done_o) n_seqd++;
    if (cfg_ram_rd_o) begin
      addr_log[n_rd % 256] = cfg_ram_addr_o;
      n_rd++;
    end
  end

  // Sensor model: done pulse exactly done_delay cycles after the start pulse
  int done_delay = 200;
  bit sens_en    = 1'b0;
  initial begin
    int pend;
    pend = 0;
    sens_done_in = 1'b0;
    forever begin
      @(negedge clk);
      sens_done_in = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) sens_done_in = 1'b1;
      end
      if (sens_start_o && sens_en) pend = done_delay;
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {13'd0, cfg_ram_rd_o, cfg_ram_addr_o, sens_start_o, sens_soft_reset_o,
            sp_o, ep_o, scan_idx_o, busy_o, seq_done_o, err_o, err_code_o};
  endfunction

  task automatic load_cfg(input logic [31:0] ctrl, input logic [31:0] stp,
                          input logic [31:0] pw, input logic [31:0] scan,
                          input logic [31:0] sp, input logic [31:0] ep);
    mem[0] = ctrl;
    mem[1] = 32'h0000_0BAD;
    mem[2] = stp;
    mem[3] = pw;
    mem[4] = scan;
    mem[5] = sp;
    mem[6] = ep;
  endtask

  task automatic pulse_start(output int hs);
    @(negedge clk);
    host_start = 1'b1;
    hs = cyc;
    @(negedge clk);
    host_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, busy_o, 1'b0);
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (n_start < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_starts_seen"}, (n_start >= n), 1'b1);
  endtask

  function automatic logic [47:0] addr_sig(input int base);
    logic [47:0] s;
    s = '0;
    for (int i = 0; i < 6; i++) s = {s[39:0], addr_log[(base + i) % 256]};
    return s;
  endfunction

  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] scan;
    logic [31:0] sp;
    logic [31:0] ep;
    logic [2:0]  code;
  } errvec_t;

  errvec_t ev [0:4];

  initial begin
    int b_st, b_rd, b_sd, hs, dummy, k;

    rst        = 1'b1;
    host_start = 1'b0;
    host_abort = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);

    ev[0] = '{32'd1, 32'd3, 32'd300, 32'd100, 3'd3};
    ev[1] = '{32'd1, 32'd0, 32'd0,   32'd10,  3'd2};
    ev[2] = '{32'd0, 32'd3, 32'd0,   32'd10,  3'd1};
    ev[3] = '{32'd1, 32'd3, 32'd0,   32'd512, 3'd3};
    ev[4] = '{32'd0, 32'd0, 32'd300, 32'd100, 3'd1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outputs", outs(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs(), 64'd0);

    // Three one-shot scans, done after 200 cycles, STP=10
    load_cfg(32'd1, 32'd10, 32'd500, 32'd3, 32'd0, 32'd511);
    sens_en = 1'b1;
    done_delay = 200;
    b_st = n_start; b_rd = n_rd; b_sd = n_seqd;
    pulse_start(hs);
    wait_starts("t1", b_st + 1, 50);
    pulse_start(dummy);  // busy: must be ignored
    wait_idle("t1", 2000);
    check("t1_first_start_lat", start_cyc[b_st % 64] - hs, 9);
    check("t1_gap_1_2", start_cyc[(b_st + 1) % 64] - start_cyc[b_st % 64], 211);
    check("t1_gap_2_3", start_cyc[(b_st + 2) % 64] - start_cyc[(b_st + 1) % 64], 211);
    check("t1_n_starts", n_start - b_st, 3);
    check("t1_scan_idx", scan_idx_o, 16'd3);
    check("t1_seq_done", n_seqd - b_sd, 1);
    check("t1_err", err_o, 1'b0);
    check("t1_n_reads", n_rd - b_rd, 6);
    check("t1_addr_order", addr_sig(b_rd), 48'h00_02_03_04_05_06);
    check("t1_sp_ep", {sp_o, ep_o}, {9'd0, 9'd511});

    // Sensor never answers: timeout after PW=500 cycles
    sens_en = 1'b0;
    b_st = n_start;
    pulse_start(hs);
    k = 0;
    while (!sens_soft_reset_o && k < 800) begin
      @(negedge clk);
      k++;
    end
    check("t2_srst", sens_soft_reset_o, 1'b1);
    check("t2_tmo_len", cyc - start_cyc[b_st % 64], 501);
    check("t2_err_code", err_code_o, 3'd4);
    check("t2_err", err_o, 1'b1);
    check("t2_busy_in_err", busy_o, 1'b1);
    @(negedge clk);
    check("t2_busy_after", busy_o, 1'b0);
    check("t2_srst_width", sens_soft_reset_o, 1'b0);

    // Validation errors and their priority
    for (int v = 0; v < 5; v++) begin
      load_cfg(ev[v].ctrl, 32'd10, 32'd500, ev[v].scan, ev[v].sp, ev[v].ep);
      b_st = n_start;
      pulse_start(hs);
      check($sformatf("t3_%0d_err_cleared", v), err_o, 1'b0);
      wait_idle($sformatf("t3_%0d", v), 50);
      check($sformatf("t3_%0d_code", v), err_code_o, ev[v].code);
      check($sformatf("t3_%0d_err", v), err_o, 1'b1);
      check($sformatf("t3_%0d_no_start", v), n_start - b_st, 0);
    end

    // Continuous mode, STP=0, abort during the 5th WAIT
    load_cfg(32'd3, 32'd0, 32'd500, 32'd0, 32'd0, 32'd511);
    sens_en = 1'b1;
    done_delay = 20;
    b_st = n_start;
    pulse_start(hs);
    wait_starts("t4", b_st + 5, 400);
    repeat (4) @(negedge clk);
    host_abort = 1'b1;
    @(negedge clk);
    host_abort = 1'b0;
    check("t4_srst", sens_soft_reset_o, 1'b1);
    check("t4_err_code", err_code_o, 3'd5);
    check("t4_err", err_o, 1'b1);
    check("t4_scan_idx", scan_idx_o, 16'd4);
    check("t4_busy", busy_o, 1'b0);
    check("t4_gap_stp0", start_cyc[(b_st + 1) % 64] - start_cyc[b_st % 64], 22);
    check("t4_gap_4_5", start_cyc[(b_st + 4) % 64] - start_cyc[(b_st + 3) % 64], 22);
    repeat (30) @(negedge clk);

    // Done on the last timeout cycle wins; one cycle later is a timeout
    load_cfg(32'd1, 32'd0, 32'd20, 32'd1, 32'd0, 32'd511);
    done_delay = 20;
    b_sd = n_seqd;
    pulse_start(hs);
    wait_idle("t5a", 100);
    check("t5a_err", err_o, 1'b0);
    check("t5a_scan_idx", scan_idx_o, 16'd1);
    check("t5a_seq_done", n_seqd - b_sd, 1);
    done_delay = 21;
    pulse_start(hs);
    wait_idle("t5b", 100);
    check("t5b_err_code", err_code_o, 3'd4);
    check("t5b_scan_idx", scan_idx_o, 16'd0);
    repeat (5) @(negedge clk);

    // PW=0 selects the default timeout rather than an immediate expiry
    load_cfg(32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd511);
    done_delay = 50;
    pulse_start(hs);
    wait_idle("t5c", 300);
    check("t5c_err", err_o, 1'b0);
    check("t5c_scan_idx", scan_idx_o, 16'd1);

    // Window capture and STP spacing
    load_cfg(32'd1, 32'd3, 32'd100, 32'd2, 32'd5, 32'd400);
    done_delay = 30;
    b_st = n_start;
    pulse_start(hs);
    wait_idle("t6", 500);
    check("t6_sp", sp_o, 9'd5);
    check("t6_ep", ep_o, 9'd400);
    check("t6_scan_idx", scan_idx_o, 16'd2);
    check("t6_gap_stp3", start_cyc[(b_st + 1) % 64] - start_cyc[b_st % 64], 34);
    check("t6_err", err_o, 1'b0);

    // Reset in the middle of PERIOD, then a clean restart
    load_cfg(32'd1, 32'd50, 32'd100, 32'd3, 32'd5, 32'd400);
    done_delay = 10;
    b_st = n_start;
    pulse_start(hs);
    wait_starts("t7", b_st + 1, 50);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t7_rst_outputs", outs(), 64'd0);
    rst = 1'b0;
    b_rd = n_rd;
    pulse_start(hs);
    wait_idle("t7", 1000);
    check("t7_n_reads", n_rd - b_rd, 6);
    check("t7_addr_order", addr_sig(b_rd), 48'h00_02_03_04_05_06);
    check("t7_scan_idx", scan_idx_o, 16'd3);
    check("t7_sp", sp_o, 9'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
